// File: rtl/corr_intdump.sv
// corr_intdump
// Early/prompt/late correlator with integrate-and-dump for one tracking channel.
// Carrier-wiped I/Q samples are multiplied by the resynchronised E/P/L PN chips.
// Six saturating sums are accumulated over DUMP_EPOCHS code epochs. Each dump
// copies the sums into holding registers, and a valid/ack handshake guards them.
//
// Ports:
//   clk, res              sample clock, asynchronous active-low reset
//   trk_en                channel enable (low forces IDLE)
//   sample_en             strobe qualifying i_samp / q_samp
//   i_samp, q_samp        signed SAMP_W-bit baseband samples
//   pne, pnp, pnl         E/P/L chips from the code generator (foreign domain)
//   epochrx               code-epoch marker (foreign domain)
//   ie..ql                signed ACC_W-bit dump registers
//   dump_valid, dump_ack  result handshake
//   sat                   an accumulator clamped during the dumped interval
//   overrun               sticky: a dump overwrote an unacknowledged result
module corr_intdump #(
  parameter int SAMP_W      = 3,
  parameter int ACC_W       = 16,
  parameter int DUMP_EPOCHS = 1
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     trk_en,
  input  logic                     sample_en,
  input  logic signed [SAMP_W-1:0] i_samp,
  input  logic signed [SAMP_W-1:0] q_samp,
  input  logic                     pne,
  input  logic                     pnp,
  input  logic                     pnl,
  input  logic                     epochrx,
  output logic signed [ACC_W-1:0]  ie,
  output logic signed [ACC_W-1:0]  ip,
  output logic signed [ACC_W-1:0]  il,
  output logic signed [ACC_W-1:0]  qe,
  output logic signed [ACC_W-1:0]  qp,
  output logic signed [ACC_W-1:0]  ql,
  output logic                     dump_valid,
  input  logic                     dump_ack,
  output logic                     sat,
  output logic                     overrun
);

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] DUMP_CNT = CNT_W'(DUMP_EPOCHS);

  typedef enum logic [1:0] {IDLE, ALIGN, INTEG} state_t;

  state_t                   state, state_nxt;
  logic [1:0]               pne_sync, pnp_sync, pnl_sync;
  logic [2:0]               epoch_sync;
  logic                     epoch_evt;
  logic [2:0]               chip;
  logic [CNT_W-1:0]         epoch_cnt, cnt_nxt, cnt_inc;
  logic                     sat_acc, sat_acc_nxt;
  logic                     dump, start, accumulate, clamp;
  logic signed [ACC_W-1:0]  i_ext, q_ext;
  logic signed [ACC_W-1:0]  prod     [6];
  logic signed [ACC_W-1:0]  acc      [6];
  logic signed [ACC_W-1:0]  acc_nxt  [6];
  logic signed [ACC_W-1:0]  base     [6];
  logic [ACC_W:0]           add_res  [6];
  logic signed [ACC_W-1:0]  hold     [6];

  // Saturating add. The MSB of the result flags a clamp.
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [ACC_W-1:0] b);
    logic [ACC_W:0] sum;
    sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      if (sum[ACC_W]) return {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
      else            return {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
    end
    return {1'b0, sum[ACC_W-1:0]};
  endfunction

  // Two-flop synchronisers for the chips. The epoch marker gets a third flop
  // so that its rising edge can be detected.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      pne_sync   <= '0;
      pnp_sync   <= '0;
      pnl_sync   <= '0;
      epoch_sync <= '0;
    end else begin
      pne_sync   <= {pne_sync[0], pne};
      pnp_sync   <= {pnp_sync[0], pnp};
      pnl_sync   <= {pnl_sync[0], pnl};
      epoch_sync <= {epoch_sync[1:0], epochrx};
    end
  end

  assign epoch_evt = epoch_sync[1] & ~epoch_sync[2];
  assign chip      = {pnl_sync[1], pnp_sync[1], pne_sync[1]};
  assign cnt_inc   = epoch_cnt + CNT_W'(1);

  // Products: sign-extend first, so negating the most negative sample is exact.
  always_comb begin
    i_ext = {{(ACC_W-SAMP_W){i_samp[SAMP_W-1]}}, i_samp};
    q_ext = {{(ACC_W-SAMP_W){q_samp[SAMP_W-1]}}, q_samp};
    for (int k = 0; k < 3; k++) begin
      prod[k]   = chip[k] ? i_ext : -i_ext;
      prod[k+3] = chip[k] ? q_ext : -q_ext;
    end
  end

  // Next state, epoch counting and accumulator update. A start (first ALIGN
  // epoch or a dump) restarts the sums from the product of the same cycle.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = epoch_cnt;
    dump        = 1'b0;
    start       = 1'b0;
    accumulate  = 1'b0;
    clamp       = 1'b0;
    sat_acc_nxt = sat_acc;
    for (int k = 0; k < 6; k++) begin
      acc_nxt[k] = acc[k];
      base[k]    = acc[k];
      add_res[k] = '0;
    end

    if (!trk_en) begin
      state_nxt   = IDLE;
      cnt_nxt     = '0;
      sat_acc_nxt = 1'b0;
      for (int k = 0; k < 6; k++) acc_nxt[k] = '0;
    end else begin
      case (state)
        IDLE: state_nxt = ALIGN;
        ALIGN: begin
          if (epoch_evt) begin
            state_nxt = INTEG;
            cnt_nxt   = '0;
            start     = 1'b1;
          end
        end
        INTEG: begin
          accumulate = 1'b1;
          if (epoch_evt) begin
            if (cnt_inc == DUMP_CNT) begin
              dump    = 1'b1;
              start   = 1'b1;
              cnt_nxt = '0;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase

      if (accumulate || start) begin
        for (int k = 0; k < 6; k++) begin
          base[k]    = start ? '0 : acc[k];
          add_res[k] = sat_add(base[k], prod[k]);
          if (sample_en) begin
            acc_nxt[k] = add_res[k][ACC_W-1:0];
            clamp      = clamp | add_res[k][ACC_W];
          end else begin
            acc_nxt[k] = base[k];
          end
        end
        sat_acc_nxt = (start ? 1'b0 : sat_acc) | clamp;
      end
    end
  end

  // Channel state and running sums.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state     <= IDLE;
      epoch_cnt <= '0;
      sat_acc   <= 1'b0;
      for (int k = 0; k < 6; k++) acc[k] <= '0;
    end else begin
      state     <= state_nxt;
      epoch_cnt <= cnt_nxt;
      sat_acc   <= sat_acc_nxt;
      for (int k = 0; k < 6; k++) acc[k] <= acc_nxt[k];
    end
  end

  // Dump registers and handshake. A dump that coincides with an ack is not an
  // overrun, because the consumer has already taken the previous result.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      dump_valid <= 1'b0;
      sat        <= 1'b0;
      overrun    <= 1'b0;
      for (int k = 0; k < 6; k++) hold[k] <= '0;
    end else if (dump) begin
      dump_valid <= 1'b1;
      sat        <= sat_acc;
      overrun    <= overrun | (dump_valid & ~dump_ack);
      for (int k = 0; k < 6; k++) hold[k] <= acc[k];
    end else begin
      if (dump_valid && dump_ack) dump_valid <= 1'b0;
      if (!trk_en) overrun <= 1'b0;
    end
  end

  assign ie = hold[0];
  assign ip = hold[1];
  assign il = hold[2];
  assign qe = hold[3];
  assign qp = hold[4];
  assign ql = hold[5];

endmodule

// File: tb/tb_corr_intdump.sv
// tb_corr_intdump
// Directed bench for corr_intdump. dut1 uses the default parameters
// (single-epoch dumps, 16-bit sums). dut2 uses 8-bit sums and three-epoch
// intervals, so saturation and multi-epoch counting are reached in few cycles.
module tb_corr_intdump;

  logic clk = 1'b0;
  logic res, trk_en, trk_en2, sample_en, pne, pnp, pnl, epochrx, dump_ack;
  logic signed [2:0]  i_samp, q_samp;
  logic signed [15:0] ie, ip, il, qe, qp, ql;
  logic               dump_valid, sat, overrun;
  logic signed [7:0]  ie2, ip2, il2, qe2, qp2, ql2;
  logic               dump_valid2, sat2, overrun2;
  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  corr_intdump dut1 (
    .clk(clk), .res(res), .trk_en(trk_en), .sample_en(sample_en),
    .i_samp(i_samp), .q_samp(q_samp), .pne(pne), .pnp(pnp), .pnl(pnl),
    .epochrx(epochrx), .ie(ie), .ip(ip), .il(il), .qe(qe), .qp(qp), .ql(ql),
    .dump_valid(dump_valid), .dump_ack(dump_ack), .sat(sat), .overrun(overrun)
  );

  corr_intdump #(.SAMP_W(3), .ACC_W(8), .DUMP_EPOCHS(3)) dut2 (
    .clk(clk), .res(res), .trk_en(trk_en2), .sample_en(sample_en),
    .i_samp(i_samp), .q_samp(q_samp), .pne(pne), .pnp(pnp), .pnl(pnl),
    .epochrx(epochrx), .ie(ie2), .ip(ip2), .il(il2), .qe(qe2), .qp(qp2), .ql(ql2),
    .dump_valid(dump_valid2), .dump_ack(dump_ack), .sat(sat2), .overrun(overrun2)
  );

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Feed n qualified samples of constant value.
  task automatic applyStimulus(input int n, input logic signed [2:0] i_val,
                               input logic signed [2:0] q_val);
    i_samp    = i_val;
    q_samp    = q_val;
    sample_en = 1'b1;
    tick(n);
    sample_en = 1'b0;
  endtask

  // Set the chips and let them cross the synchroniser.
  task automatic setChips(input logic e, input logic p, input logic l);
    pne = e;
    pnp = p;
    pnl = l;
    tick(3);
  endtask

  // Epoch pulse. The event is seen on the second edge, and the dump lands on
  // the third edge. ack_in_dump raises dump_ack exactly for that third edge.
  task automatic pulseEpoch(input logic ack_in_dump);
    epochrx = 1'b1;
    tick(2);
    epochrx  = 1'b0;
    dump_ack = ack_in_dump;
    tick(1);
    dump_ack = 1'b0;
    tick(4);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    res = 1'b0; trk_en = 1'b0; trk_en2 = 1'b0; sample_en = 1'b0;
    i_samp = '0; q_samp = '0; pne = 1'b0; pnp = 1'b0; pnl = 1'b0;
    epochrx = 1'b0; dump_ack = 1'b0;
    tick(3);
    checkOutput("rst_ip", ip, 0);
    checkOutput("rst_qp", qp, 0);
    checkOutput("rst_dv", dump_valid, 0);
    checkOutput("rst_sat", sat, 0);
    checkOutput("rst_ovr", overrun, 0);
    res = 1'b1;
    tick(2);

    // Disabled channel with samples and epochs running.
    setChips(1'b1, 1'b1, 1'b1);
    applyStimulus(20, 3'sd1, 3'sd1);
    pulseEpoch(1'b0);
    applyStimulus(20, 3'sd1, 3'sd1);
    pulseEpoch(1'b0);
    checkOutput("idle_dv", dump_valid, 0);
    checkOutput("idle_ip", ip, 0);

    // Enable mid-epoch: these pre-epoch samples must be discarded.
    trk_en = 1'b1;
    tick(2);
    applyStimulus(5, 3'sd1, -3'sd2);
    pulseEpoch(1'b0);
    applyStimulus(2046, 3'sd1, -3'sd2);
    pulseEpoch(1'b0);
    checkOutput("corr_ip", ip, 2046);
    checkOutput("corr_ie", ie, 2046);
    checkOutput("corr_il", il, 2046);
    checkOutput("corr_qp", qp, -4092);
    checkOutput("corr_qe", qe, -4092);
    checkOutput("corr_sat", sat, 0);
    checkOutput("corr_dv", dump_valid, 1);
    checkOutput("corr_ovr", overrun, 0);
    tick(5);
    checkOutput("dv_held", dump_valid, 1);
    dump_ack = 1'b1;
    tick(1);
    dump_ack = 1'b0;
    checkOutput("dv_acked", dump_valid, 0);

    // Chip 0 negates. The most negative sample maps to +4 exactly.
    setChips(1'b1, 1'b0, 1'b1);
    applyStimulus(10, -3'sd4, 3'sd0);
    pulseEpoch(1'b0);
    checkOutput("sign_ip", ip, 40);
    checkOutput("sign_ie", ie, -40);
    checkOutput("sign_il", il, -40);
    checkOutput("sign_qp", qp, 0);
    checkOutput("sign_dv", dump_valid, 1);

    // Second dump without an ack overwrites the result and flags overrun.
    setChips(1'b1, 1'b1, 1'b1);
    applyStimulus(3, 3'sd1, 3'sd1);
    pulseEpoch(1'b0);
    checkOutput("ovr_ip", ip, 3);
    checkOutput("ovr_qp", qp, 3);
    checkOutput("ovr_flag", overrun, 1);
    checkOutput("ovr_dv", dump_valid, 1);

    // Dropping trk_en mid-interval: no dump, result retained, overrun cleared.
    applyStimulus(4, 3'sd1, 3'sd1);
    trk_en = 1'b0;
    tick(2);
    pulseEpoch(1'b0);
    checkOutput("dis_ovr", overrun, 0);
    checkOutput("dis_dv", dump_valid, 1);
    checkOutput("dis_ip", ip, 3);

    // Re-align, then dump with the ack in the dump cycle while still valid.
    trk_en = 1'b1;
    tick(2);
    pulseEpoch(1'b0);
    applyStimulus(7, 3'sd2, 3'sd0);
    pulseEpoch(1'b1);
    checkOutput("simack_ip", ip, 14);
    checkOutput("simack_dv", dump_valid, 1);
    checkOutput("simack_ovr", overrun, 0);
    dump_ack = 1'b1;
    tick(1);
    dump_ack = 1'b0;
    checkOutput("simack_clr", dump_valid, 0);
    trk_en = 1'b0;

    // dut2: three-epoch intervals, 8-bit sums saturate.
    trk_en2 = 1'b1;
    tick(2);
    pulseEpoch(1'b0);
    for (int e = 0; e < 3; e++) begin
      applyStimulus(20, 3'sd3, -3'sd3);
      pulseEpoch(1'b0);
      if (e < 2) checkOutput("multi_dv", dump_valid2, 0);
    end
    checkOutput("sat_ip", ip2, 127);
    checkOutput("sat_ie", ie2, 127);
    checkOutput("sat_qp", qp2, -128);
    checkOutput("sat_flag", sat2, 1);
    checkOutput("sat_dv", dump_valid2, 1);
    dump_ack = 1'b1;
    tick(1);
    dump_ack = 1'b0;
    for (int e = 0; e < 3; e++) pulseEpoch(1'b0);
    checkOutput("zero_ip", ip2, 0);
    checkOutput("zero_sat", sat2, 0);
    checkOutput("zero_dv", dump_valid2, 1);
    checkOutput("zero_ovr", overrun2, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
